// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an async PWM input and measures high time and period in clk cycles.
// Optional 2-sample deglitch filter after the synchronizer: define PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             busy,
  output logic             timeout,
  output logic             level
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] MEAS_HIGH = 2'd2;
  localparam logic [1:0] MEAS_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  // Input synchronizer; keeps running while disabled so re-enable sees a settled level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  logic filt_q;

  // Accept a new level only once the last two synchronizer stages agree on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) begin
      filt_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s = filt_q;
`else
  assign s = sync_q[SYNC_STAGES-1];
`endif

  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;
  assign level = s;

  logic [1:0]       state_q;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] htmp_q;
  logic [CNT_W-1:0] htmp_n;
  logic [CNT_W-1:0] high_n;
  logic [CNT_W-1:0] period_n;
  logic             valid_n;
  logic             timeout_n;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_sat = (cnt_q == CNT_MAX);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

  // Next-state and next-output logic; an edge takes priority over saturation.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    htmp_n    = htmp_q;
    high_n    = high_cnt;
    period_n  = period_cnt;
    valid_n   = 1'b0;
    timeout_n = timeout;
    if (!en) begin
      state_n   = IDLE;
      cnt_n     = '0;
      timeout_n = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_n = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_n   = CNT_ONE;
            state_n = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            htmp_n  = cnt_q;
            cnt_n   = cnt_inc;
            state_n = MEAS_LOW;
          end else if (cnt_sat) begin
            timeout_n = 1'b1;
            state_n   = WAIT_RISE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            period_n  = cnt_q;
            high_n    = htmp_q;
            valid_n   = 1'b1;
            timeout_n = 1'b0;
            cnt_n     = CNT_ONE;
            state_n   = MEAS_HIGH;
          end else if (cnt_sat) begin
            timeout_n = 1'b1;
            state_n   = WAIT_RISE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      htmp_q     <= '0;
      s_d        <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      htmp_q     <= htmp_n;
      s_d        <= s;
      high_cnt   <= high_n;
      period_cnt <= period_n;
      valid      <= valid_n;
      timeout    <= timeout_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: timestamp-based reference model plus directed waveforms.
module tb_pwm_capture;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned NS    = 2;
  localparam int          MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             valid;
  logic             busy;
  logic             timeout;
  logic             level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(NS)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .valid(valid),
    .busy(busy), .timeout(timeout), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Reference model: measurements are differences of edge timestamps on the delayed input.
  logic [NS-1:0]    mp = '0;
  logic             ms = 1'b0;
  logic             msd = 1'b0;
  bit               mbusy = 1'b0;
  bit               hs = 1'b0;
  bit               hf = 1'b0;
  int               t = 0;
  int               r0 = 0;
  int               f0 = 0;
  logic             e_valid = 1'b0;
  logic             e_busy = 1'b0;
  logic             e_to = 1'b0;
  logic             e_level = 1'b0;
  logic [CNT_W-1:0] e_high = '0;
  logic [CNT_W-1:0] e_per = '0;

  always @(posedge clk) begin : model
    bit rz;
    bit fl;
    rz = ms & ~msd;
    fl = ~ms & msd;
    if (rst) begin
      mp = '0; ms = 1'b0; msd = 1'b0; mbusy = 1'b0; hs = 1'b0; hf = 1'b0;
      e_valid = 1'b0; e_busy = 1'b0; e_to = 1'b0; e_level = 1'b0;
      e_high = '0; e_per = '0;
    end else begin
      e_valid = 1'b0;
      if (!en) begin
        hs = 1'b0; hf = 1'b0; e_to = 1'b0;
      end else if (mbusy) begin
        if (rz) begin
          if (hs && hf) begin
            e_valid = 1'b1;
            e_high  = CNT_W'(sat(f0 - r0));
            e_per   = CNT_W'(sat(t - r0));
            e_to    = 1'b0;
          end
          r0 = t; hs = 1'b1; hf = 1'b0;
        end else if (hs && fl && !hf) begin
          f0 = t; hf = 1'b1;
        end else if (hs && (t - r0) >= MAXC) begin
          hs = 1'b0; e_to = 1'b1;
        end
      end
      mbusy  = en;
      e_busy = en;
      msd    = ms;
`ifdef PWM_CAPTURE_DEGLITCH_EN
      if (mp[NS-1] == mp[NS-2]) ms = mp[NS-1];
      mp = {mp[NS-2:0], pwm_in};
`else
      mp = {mp[NS-2:0], pwm_in};
      ms = mp[NS-1];
`endif
      e_level = ms;
    end
    t++;
  end

  logic [CNT_W-1:0] qh[$];
  logic [CNT_W-1:0] qp[$];
  int               qt[$];

  // Every-cycle comparison against the model; strobes are logged for literal checks.
  always @(negedge clk) begin
    cyc++;
    check("valid", 32'(valid), 32'(e_valid));
    check("busy", 32'(busy), 32'(e_busy));
    check("timeout", 32'(timeout), 32'(e_to));
    check("level", 32'(level), 32'(e_level));
    check("high_cnt", 32'(high_cnt), 32'(e_high));
    check("period_cnt", 32'(period_cnt), 32'(e_per));
    if (valid === 1'b1) begin
      qh.push_back(high_cnt);
      qp.push_back(period_cnt);
      qt.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input int h, input int l, input int reps);
    repeat (reps) begin
      pwm_in = 1'b1; tick(h);
      pwm_in = 1'b0; tick(l);
    end
  endtask

  int qa;

  initial begin
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_high", 32'(high_cnt), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);

    // 3/7 stream then duty change to 8/2, then stuck high into saturation
    rst = 1'b0; en = 1'b1;
    wave(3, 7, 4);
    wave(8, 2, 3);
    pwm_in = 1'b1; tick(25);
    check("n_strobes", 32'(qh.size()), 32'd7);
    if (qh.size() >= 7) begin
      check("first_high", 32'(qh[0]), 32'd3);
      check("first_per", 32'(qp[0]), 32'd10);
      check("b1_high", 32'(qh[3]), 32'd3);
      check("b2_high", 32'(qh[4]), 32'd8);
      check("b2_per", 32'(qp[4]), 32'd10);
      check("gap34", 32'(qt[4] - qt[3]), 32'd10);
      check("gap23", 32'(qt[3] - qt[2]), 32'd10);
    end
    check("to_set", 32'(timeout), 32'd1);
    check("to_level", 32'(level), 32'd1);
    check("to_hold_high", 32'(high_cnt), 32'd8);

    // recovery with 2/3 clears timeout
    pwm_in = 1'b0; tick(3);
    wave(2, 3, 3);
    check("rec_strobes", 32'(qh.size()), 32'd9);
    check("rec_high", 32'(high_cnt), 32'd2);
    check("rec_per", 32'(period_cnt), 32'd5);
    check("rec_to", 32'(timeout), 32'd0);

    // reset during the low phase
    pwm_in = 1'b1; tick(3);
    pwm_in = 1'b0; tick(4);
    rst = 1'b1; tick(1);
    check("mrst_high", 32'(high_cnt), 32'd0);
    check("mrst_per", 32'(period_cnt), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_to", 32'(timeout), 32'd0);
    rst = 1'b0;
    qa = qh.size();
    wave(3, 7, 3);
    check("post_rst_strobes", 32'(qh.size() - qa), 32'd2);

    // enable dropped in the high phase, then re-enabled with 4/4
    pwm_in = 1'b1; tick(4);
    en = 1'b0; tick(1);
    check("endrop_busy", 32'(busy), 32'd0);
    check("endrop_high", 32'(high_cnt), 32'd3);
    check("endrop_per", 32'(period_cnt), 32'd10);
    en = 1'b1; pwm_in = 1'b0; tick(4);
    qa = qh.size();
    wave(4, 4, 3);
    check("reen_strobes", 32'(qh.size() - qa), 32'd2);
    check("reen_high", 32'(high_cnt), 32'd4);
    check("reen_per", 32'(period_cnt), 32'd8);

    // 1-cycle glitches, period 6
    qa = qh.size();
    wave(1, 5, 4);
`ifdef PWM_CAPTURE_DEGLITCH_EN
    check("glitch_strobes", 32'(qh.size() - qa), 32'd0);
    check("glitch_level", 32'(level), 32'd0);
`else
    check("glitch_strobes", 32'(qh.size() - qa), 32'd4);
    check("glitch_high", 32'(high_cnt), 32'd1);
    check("glitch_per", 32'(period_cnt), 32'd6);
`endif
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart to the team's PWM generator.
- Samples an asynchronous PWM input and measures its high time and period in clk cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Sits between a PWM source (generator output or external pin) and control logic that needs duty/period feedback.

Parameters:
- CNT_W, 16, width of the internal counter and of the high_cnt/period_cnt outputs.
- SYNC_STAGES, 2, number of flops in the input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  measurement enable; 0 forces IDLE
- pwm_in  input  1  asynchronous PWM input
- high_cnt  output  CNT_W  cycles the input was high in the last complete period
- period_cnt  output  CNT_W  cycles between the last two rising edges
- valid  output  1  one-cycle strobe; high_cnt/period_cnt updated this cycle
- busy  output  1  high in WAIT_RISE/MEAS_HIGH/MEAS_LOW
- timeout  output  1  level; counter saturated with no edge
- level  output  1  synchronized input level, registered

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, counter=0, sync flops=0, edge-history flop=0, all outputs=0. Reset mid-measurement discards the partial period.
- Synchronizer: pwm_in passes through SYNC_STAGES flops, giving s. A history flop s_d gives rise = s & ~s_d and fall = ~s & s_d. level = s.
- States:
  - IDLE: busy=0. If en=1, go to WAIT_RISE.
  - WAIT_RISE: on rise, counter<=1 and go to MEAS_HIGH. The first partial period is never reported.
  - MEAS_HIGH: counter increments each cycle. On fall, latch high_tmp<=counter and go to MEAS_LOW.
  - MEAS_LOW: counter increments. On rise: period_cnt<=counter, high_cnt<=high_tmp, valid<=1, counter<=1, go to MEAS_HIGH (back-to-back measurement, no dead period).
- Counting rule: high_cnt = number of clk cycles s was high; period_cnt = high cycles + low cycles.
- Minimum legal measurement: high_cnt=1, period_cnt=2.
- Latency: valid asserts at the clk edge after rise is detected on s, i.e. SYNC_STAGES+1 edges after the first edge that samples pwm_in high.
- Saturation/timeout: if counter reaches 2^CNT_W-1 in MEAS_HIGH or MEAS_LOW:
  - counter holds, timeout<=1, go to WAIT_RISE.
  - high_cnt/period_cnt hold their previous values; no valid strobe.
  - level indicates the stuck value (0%/100% duty).
  - timeout clears on the next valid strobe, on en=0, or on reset.
- en=0 in any state: next state IDLE, counter<=0, timeout<=0; high_cnt/period_cnt hold. The synchronizer keeps running so that re-enable sees a clean s.
- Rise and fall cannot coincide on one signal. A rise seen in MEAS_HIGH (impossible) is ignored.
- Output hold: valid is high for exactly one cycle per completed period. high_cnt/period_cnt change only on valid.

Optional Feature:
- Macro: PWM_CAPTURE_DEGLITCH_EN.
- When defined:
  - A 2-sample stability filter follows the synchronizer.
  - s changes only after the synchronized input has held the new value for 2 consecutive cycles.
  - Pulses or gaps of 1 cycle are ignored.
  - Latency grows by 1 cycle.
  - Measured widths are unchanged for pulses of 2 or more cycles.
- When undefined: no filter; 1-cycle pulses are measured (high_cnt=1).

Test Plan:
- Reset then en=1, pwm_in repeating 3 high / 7 low -> first period ignored; every following rising edge gives valid=1 for 1 cycle with high_cnt=3, period_cnt=10; busy=1.
- Duty change mid-stream from 3/7 to 8/2 -> the next strobe reports 8/10; no strobe with mixed values; strobes are 10 cycles apart.
- CNT_W=4, pwm_in held high after a rise -> after 15 counted cycles, timeout=1, level=1, no valid; a later 2/3 waveform gives valid with high_cnt=2, period_cnt=5 and timeout=0.
- rst=1 during MEAS_LOW -> next cycle all outputs 0, state IDLE; after release, first report only after two rising edges.
- en dropped during MEAS_HIGH -> busy=0 next cycle, outputs hold last values; re-enable with 4/4 input -> valid with 4/8 after one discarded partial period.
- 1-cycle high glitch, period 6 -> without macro high_cnt=1, period_cnt=6; with PWM_CAPTURE_DEGLITCH_EN no rise accepted and no valid.
